// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared loader state encoding, image format constant and address helper
package riscv_defs;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LEN   = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_ERR   = 3'd5;

    localparam int BYTES_PER_WORD = 4;

    // Byte address of word idx; wraps at 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word assembler with a word_full pulse
module word_assembler
    import riscv_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (take_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[31:8]};
        end
    end

    // Shifting right leaves byte k in bits [8k+7:8k] once the fourth byte lands.
    assign word_o      = {byte_i, shift_q[31:8]};
    assign word_full_o = take_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed little-endian image into memory while holding the CPU in init
module program_loader
    import riscv_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        cpu_init_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        restart, take, word_full;
    logic [31:0] word;

    assign restart = start_i && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign take    = byte_valid_i && byte_ready_o;

    word_assembler u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (restart),
        .take_i      (take),
        .byte_i      (byte_data_i),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_LEN;
                    idx_d   = '0;
                    n_d     = '0;
                end
            end
            ST_LEN: begin
                if (word_full) begin
                    n_d = word;
                    if (word == '0)        state_d = ST_DONE;
                    else if (word > MAX_N) state_d = ST_ERR;
                    else                   state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Write address and data are registered here so WRITE drives them straight from flops.
                if (word_full) begin
                    addr_d  = word_addr(BASE_ADDR, idx_q);
                    wd_d    = word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == n_q) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign byte_ready_o = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign mem_we_o     = (state_q == ST_WRITE);
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign cpu_init_o   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign load_done_o  = (state_q == ST_DONE);
    assign load_err_o   = (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a byte-stream reference model
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o, mem_we_o, cpu_init_o, load_done_o, load_err_o;
    logic [31:0] mem_addr_o, mem_wd_o;

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .cpu_init_o   (cpu_init_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a load is a stream of accepted bytes; every 4th data byte schedules one write cycle.
    bit          m_active, m_write, m_done, m_err;
    int          m_taken, m_written;
    logic [31:0] m_len, m_word, m_exp_addr, m_exp_wd;

    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_wd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_write = 0; m_done = 0; m_err = 0;
        m_taken = 0; m_written = 0; m_len = '0; m_word = '0;
    endtask

    task automatic step(input bit st, input bit vld, input logic [7:0] d, output bit took);
        bit ready_exp;
        int k;
        start_i = st; byte_valid_i = vld; byte_data_i = d;
        @(negedge clk_i);
        ready_exp = m_active && !m_write;
        check("byte_ready", byte_ready_o, ready_exp);
        check("cpu_init",   cpu_init_o,   m_active);
        check("mem_we",     mem_we_o,     m_write);
        check("load_done",  load_done_o,  m_done);
        check("load_err",   load_err_o,   m_err);
        if (m_write) begin
            check("mem_addr", mem_addr_o, m_exp_addr);
            check("mem_wd",   mem_wd_o,   m_exp_wd);
        end
        if (mem_we_o === 1'b1) begin
            wlog_addr.push_back(mem_addr_o);
            wlog_wd.push_back(mem_wd_o);
        end
        took = vld && ready_exp;
        if (st && !m_active) begin
            m_reset();
            m_active = 1;
        end else if (m_active) begin
            if (m_write) begin
                m_write = 0;
                if (32'(m_written) == m_len) begin m_active = 0; m_done = 1; end
            end else if (vld) begin
                if (m_taken < 4) begin
                    m_len[8*m_taken +: 8] = d;
                    m_taken++;
                    if (m_taken == 4) begin
                        if (m_len == 0)                begin m_active = 0; m_done = 1; end
                        else if (m_len > 32'(MAXW))    begin m_active = 0; m_err = 1; end
                    end
                end else begin
                    k = (m_taken - 4) % 4;
                    m_word[8*k +: 8] = d;
                    m_taken++;
                    if (k == 3) begin
                        m_exp_addr = BASE + 32'(4 * m_written);
                        m_exp_wd   = m_word;
                        m_written++;
                        m_write = 1;
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_load(input bq_t img, input int vpct, input int spct, input int abort_after);
        int ptr, cyc, extra, exp_cons;
        bit took, v, s;
        logic [7:0]  d;
        logic [31:0] n;
        ptr = 0; cyc = 0; extra = 0;
        n = {img[3], img[2], img[1], img[0]};
        exp_cons = (n == 0 || n > 32'(MAXW)) ? 4 : 4 + 4 * int'(n);
        step(1'b1, 1'b0, 8'h00, took);
        while (extra < 3 && cyc < 3000) begin
            v = ($urandom_range(99) < vpct);
            d = (ptr < img.size()) ? img[ptr] : 8'($urandom);
            s = m_active && ($urandom_range(99) < spct);
            step(s, v, d, took);
            if (took) ptr++;
            cyc++;
            if (abort_after >= 0 && ptr >= abort_after) return;
            if (!m_active) extra++;
        end
        check("load_finished_in_budget", 32'(cyc < 3000), 32'd1);
        check("bytes_consumed", 32'(ptr), 32'(exp_cons));
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0;
        m_reset();
        #2;
        check("rst_byte_ready", byte_ready_o, 0);
        check("rst_mem_we",     mem_we_o,     0);
        check("rst_mem_addr",   mem_addr_o,   0);
        check("rst_mem_wd",     mem_wd_o,     0);
        check("rst_cpu_init",   cpu_init_o,   0);
        check("rst_load_done",  load_done_o,  0);
        check("rst_load_err",   load_err_o,   0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    function automatic bq_t make_image(input int n, input bit rnd);
        bq_t q;
        for (int i = 0; i < 4; i++) q.push_back(8'(n >> (8 * i)));
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 4; b++) q.push_back(rnd ? 8'($urandom) : 8'(w * 16 + b));
        return q;
    endfunction

    initial begin
        bq_t img;
        bit took;
        @(posedge clk_i);
        #1;
        do_reset();
        step(1'b0, 1'b1, 8'hA5, took);

        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wlog_addr.delete(); wlog_wd.delete();
        run_load(img, 100, 0, -1);
        check("two_word_count", 32'(wlog_addr.size()), 32'd2);
        if (wlog_addr.size() == 2) begin
            check("w0_addr", wlog_addr[0], 32'h0000_0000);
            check("w0_data", wlog_wd[0],   32'h1234_5678);
            check("w1_addr", wlog_addr[1], 32'h0000_0004);
            check("w1_data", wlog_wd[1],   32'hDEAD_BEEF);
        end
        check("two_word_done", load_done_o, 1);

        wlog_addr.delete(); wlog_wd.delete();
        run_load(make_image(0, 0), 100, 0, -1);
        check("zero_len_writes", 32'(wlog_addr.size()), 32'd0);
        check("zero_len_done", load_done_o, 1);

        wlog_addr.delete(); wlog_wd.delete();
        run_load(make_image(5, 0), 100, 0, -1);
        check("too_long_writes", 32'(wlog_addr.size()), 32'd0);
        check("too_long_err", load_err_o, 1);

        run_load(make_image(MAXW, 1), 100, 0, -1);
        run_load(make_image(3, 1), 60, 40, -1);

        run_load(make_image(1, 1), 100, 0, 6);
        do_reset();
        step(1'b0, 1'b1, 8'h5A, took);
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90};
        wlog_addr.delete(); wlog_wd.delete();
        run_load(img, 100, 0, -1);
        check("after_rst_count", 32'(wlog_addr.size()), 32'd1);
        if (wlog_addr.size() == 1) begin
            check("after_rst_addr", wlog_addr[0], BASE);
            check("after_rst_data", wlog_wd[0],   32'h90A1_B2C3);
        end

        for (int t = 0; t < 25; t++)
            run_load(make_image($urandom_range(0, 6), 1), $urandom_range(30, 100), $urandom_range(0, 20), -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
